// File: rtl/sum_window_averager.sv
// ---------------------------------------------------------------------------
// sum_window_averager
//
// Purpose:
//   Consumes the 8-bit adder sum stream one sample per valid/ready handshake,
//   accumulates a window of 2**LOG2_N samples and presents the window average
//   on a registered valid/ready output port. While the average is waiting to
//   be taken the input side is stalled (in_ready=0), so the producer holds
//   its sample and nothing is lost.
//
// Configuration macro:
//   AVG_ROUND_EN  defined   -> average rounds half up: (sum + N/2) >> LOG2_N
//                 undefined -> average truncates:      sum >> LOG2_N
//
// Parameters:
//   DATA_W  width of input samples and of the average output
//   LOG2_N  log2 of the window length, 1..6
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous reset, active-high
//   clear       in   1       synchronous clear of window and output handshake,
//                            wins over any simultaneous handshake
//   in_valid    in   1       in_data holds a sample
//   in_data     in   DATA_W  sample (adder sum)
//   in_ready    out  1       a sample is accepted this cycle if in_valid
//   out_valid   out  1       out_avg holds a completed window average
//   out_ready   in   1       consumer takes out_avg this cycle
//   out_avg     out  DATA_W  window average
//   sample_cnt  out  LOG2_N  samples accepted in the current window
// ---------------------------------------------------------------------------
module sum_window_averager #(
  parameter int DATA_W = 8,
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [LOG2_N-1:0] sample_cnt
);

  // Accumulator holds N full-scale samples without wrapping.
  localparam int ACC_W = DATA_W + LOG2_N;

  // The last sample of a window arrives when the counter is at all-ones.
  localparam logic [LOG2_N-1:0] CNT_LAST = '1;

`ifdef AVG_ROUND_EN
  // Half an LSB of the average, expressed at accumulator scale.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N - 1);
`endif

  typedef enum logic {
    S_ACC = 1'b0,
    S_OUT = 1'b1
  } state_t;

  // Divide a completed window sum by N. One extra bit of headroom keeps the
  // rounding offset from wrapping; the shifted result always fits DATA_W.
  function automatic logic [DATA_W-1:0] window_avg(input logic [ACC_W-1:0] sum);
    logic [ACC_W:0] ext;
    ext = {1'b0, sum};
`ifdef AVG_ROUND_EN
    ext = ext + HALF;
`endif
    return DATA_W'(ext >> LOG2_N);
  endfunction

  state_t            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;
  logic [LOG2_N-1:0] cnt_q;
  logic [LOG2_N-1:0] cnt_d;
  logic [DATA_W-1:0] avg_q;
  logic [DATA_W-1:0] avg_d;
  logic              accept;
  logic              window_done;
  logic              drain;

  // Handshake signals come straight from the state register, so both are
  // glitch-free and respond to rst immediately.
  assign in_ready   = (state_q == S_ACC);
  assign out_valid  = (state_q == S_OUT);
  assign out_avg    = avg_q;
  assign sample_cnt = cnt_q;

  always_comb begin
    accept      = in_valid && in_ready;
    window_done = accept && (cnt_q == CNT_LAST);
    drain       = out_valid && out_ready;
    acc_d       = acc_q + ACC_W'(in_data);
    cnt_d       = cnt_q + LOG2_N'(1);
    avg_d       = window_avg(acc_d);
  end

  // ---- accumulate / present stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      avg_q   <= '0;
    end else if (clear) begin
      // Abandon the partial window and any pending average; the last
      // average value itself is left on out_avg.
      state_q <= S_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_ACC: begin
          if (window_done) begin
            avg_q   <= avg_d;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_OUT;
          end else if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
          end
        end
        S_OUT: begin
          if (drain) begin
            state_q <= S_ACC;
          end
        end
        default: begin
          state_q <= S_ACC;
        end
      endcase
    end
  end

endmodule
